// File: rtl/ntt_ctrl_if.sv
// Bus between the NTT sequencing controller and the coefficient RAM,
// zeta ROM and butterfly write-back path. The controller is the master.
interface ntt_ctrl_if #(
  parameter int LOG_N = 8
);
  localparam int LW = $clog2(LOG_N);

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr0;
  logic [LOG_N-1:0] rd_addr1;
  logic [LOG_N-1:0] zeta_idx;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr0;
  logic [LOG_N-1:0] wr_addr1;
  logic [LW-1:0]    layer;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr0, rd_addr1, zeta_idx,
           wr_en, wr_addr0, wr_addr1, layer
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr0, rd_addr1, zeta_idx,
           wr_en, wr_addr0, wr_addr1, layer
  );
endinterface

// File: rtl/ntt_ctrl.sv
// Forward-NTT sequencing controller. Walks the LOG_N Cooley-Tukey layers,
// issuing one butterfly per cycle (read addresses + zeta index), inserts
// RD_LAT+BF_LAT drain cycles between layers, and replays each read address
// pair as the matching write address pair through a fixed delay line.
module ntt_ctrl #(
  parameter int N      = 256,
  parameter int LOG_N  = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,   // asynchronous, active-low
  ntt_ctrl_if.master bus
);

  localparam int D    = RD_LAT + BF_LAT;        // read-to-write distance
  localparam int HALF = N / 2;                  // butterflies per layer
  localparam int BW   = LOG_N - 1;              // butterfly counter width
  localparam int LW   = $clog2(LOG_N);          // layer counter width
  localparam int CW   = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic             en;
    logic [LOG_N-1:0] a0;
    logic [LOG_N-1:0] a1;
  } wr_slot_t;

  state_e           state_q, state_d;
  logic [BW-1:0]    b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    layer_q, layer_d;

  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_addr0_q, rd_addr0_d;
  logic [LOG_N-1:0] rd_addr1_q, rd_addr1_d;
  logic [LOG_N-1:0] zeta_q, zeta_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  wr_slot_t         dl_q [D];
  wr_slot_t         dl_d [D];

  // Address-generation intermediates for the butterfly about to be issued.
  int               s;
  logic [LOG_N-1:0] len, bx, g, off, a0, a1, z;

  // Next-state logic: layer/butterfly/drain counters and FSM transitions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default in always_comb infers a latch.
    state_d = state_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          layer_d = '0;
          b_d     = '0;
        end
      end
      S_ISSUE: begin
        if (b_q == BW'(HALF - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(D - 1)) begin
          if (layer_q == LW'(LOG_N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + LW'(1);
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: decode the next state so every output leaves a flop,
  // and shift the read pair down the write delay line.
  always_comb begin
    s   = (LOG_N - 1) - int'(layer_d);
    len = LOG_N'(1) << s;
    bx  = {1'b0, b_d};
    g   = bx >> s;
    off = bx & (len - LOG_N'(1));
    a0  = (g << (s + 1)) | off;
    a1  = a0 + len;
    z   = (LOG_N'(1) << layer_d) + g;

    rd_en_d    = (state_d == S_ISSUE);
    rd_addr0_d = rd_en_d ? a0 : '0;
    rd_addr1_d = rd_en_d ? a1 : '0;
    zeta_d     = rd_en_d ? z  : '0;
    busy_d     = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);

    dl_d[0] = '{en: rd_en_q, a0: rd_addr0_q, a1: rd_addr1_q};
    for (int i = 1; i < D; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  // State, counter, output and delay-line registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      cnt_q      <= '0;
      layer_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      zeta_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      // NOTE: the delay line is a small register array, not RAM, and it is
      // reset on purpose: a write still in flight when reset hits must
      // never be issued after release.
      for (int i = 0; i < D; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      layer_q    <= layer_d;
      rd_en_q    <= rd_en_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      zeta_q     <= zeta_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dl_q       <= dl_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr0 = rd_addr0_q;
  assign bus.rd_addr1 = rd_addr1_q;
  assign bus.zeta_idx = zeta_q;
  assign bus.wr_en    = dl_q[D-1].en;
  assign bus.wr_addr0 = dl_q[D-1].a0;
  assign bus.wr_addr1 = dl_q[D-1].a1;
  assign bus.layer    = layer_q;

endmodule
